// File: rtl/miso_fifo_sched.sv
`default_nettype none
// ============================================================================
// miso_fifo_sched
// Tile sequencer for a multi-input/single-output window FIFO: accepts masked
// groups, drives FIFO write/pop/clear strobes, tracks occupancy, streams out.
// Revision: 1.0
// ============================================================================
module miso_fifo_sched #(
  parameter int DEPTH       = 32,
  parameter int DATA_LENGTH = 9,
  parameter int CNT_WIDTH   = $clog2(DEPTH+1),
  parameter int GRP_WIDTH   = 16
) (
  input  logic                   i_clk,
  input  logic                   i_nrst,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [GRP_WIDTH-1:0]   i_num_groups,
  input  logic                   i_in_valid,
  input  logic [DATA_LENGTH-1:0] i_in_mask,
  output logic                   o_in_ready,
  output logic                   o_fifo_write_en,
  output logic [DATA_LENGTH-1:0] o_fifo_valid,
  output logic                   o_fifo_pop_en,
  output logic                   o_fifo_clear,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [CNT_WIDTH-1:0]   o_count,
  output logic                   o_busy,
  output logic                   o_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FILL  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] c_cap = CNT_WIDTH'(DEPTH-1);

  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_WIDTH-1:0] r_count;
  logic [CNT_WIDTH-1:0] w_count_next;
  logic [CNT_WIDTH-1:0] w_pc;
  logic [CNT_WIDTH-1:0] w_room;
  logic [GRP_WIDTH-1:0] r_num_groups;
  logic [GRP_WIDTH-1:0] r_grp_cnt;
  logic                 r_out_valid;
  logic                 w_abort;
  logic                 w_accept;
  logic                 w_write;
  logic                 w_pop;
  logic                 w_flush;
  logic                 w_last_grp;

  always_comb begin
    w_pc = '0;
    for (int i = 0; i < DATA_LENGTH; i++) begin
      w_pc = w_pc + CNT_WIDTH'(i_in_mask[i]);
    end
  end

  // Abort outranks accept and pop, so both are masked during the abort cycle.
  assign w_abort    = i_abort & (r_state != S_IDLE);
  assign w_room     = c_cap - r_count;
  assign o_in_ready = (r_state == S_FILL) & ~i_abort & (w_pc <= w_room);
  assign w_accept   = o_in_ready & i_in_valid;
  assign w_write    = w_accept & (w_pc != '0);
  assign w_pop      = ((r_state == S_FILL) | (r_state == S_DRAIN)) & ~i_abort &
                      (r_count != '0) & (~r_out_valid | i_out_ready);
  assign w_flush    = (r_state == S_CLEAR) | w_abort;
  assign w_last_grp = (r_grp_cnt + GRP_WIDTH'(1)) == r_num_groups;

  assign o_fifo_write_en = w_write;
  assign o_fifo_valid    = w_write ? i_in_mask : '0;
  assign o_fifo_pop_en   = w_pop;
  assign o_fifo_clear    = w_flush;
  assign o_out_valid     = r_out_valid;
  assign o_count         = r_count;
  assign o_busy          = (r_state != S_IDLE);
  assign o_done          = (r_state == S_DONE) & ~i_abort;

  always_comb begin
    w_count_next = r_count + (w_write ? w_pc : '0) - CNT_WIDTH'(w_pop);
    if (w_flush) begin
      w_count_next = '0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_next = S_CLEAR;
      S_CLEAR: w_state_next = (r_num_groups == '0) ? S_DRAIN : S_FILL;
      S_FILL:  if (w_accept && w_last_grp) w_state_next = S_DRAIN;
      S_DRAIN: if ((r_count == '0) && (!r_out_valid || i_out_ready)) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (w_abort) begin
      w_state_next = S_IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_num_groups <= '0;
      r_grp_cnt    <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      if ((r_state == S_IDLE) && i_start) begin
        r_num_groups <= i_num_groups;
      end
      if (r_state == S_CLEAR) begin
        r_grp_cnt <= '0;
      end else if (w_accept) begin
        r_grp_cnt <= r_grp_cnt + GRP_WIDTH'(1);
      end
      // Output register mirrors the FIFO's registered read port.
      if (w_flush) begin
        r_out_valid <= 1'b0;
      end else if (w_pop) begin
        r_out_valid <= 1'b1;
      end else if (i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
